// File: rtl/sdram_arb_pkg.sv
// Shared types and widths for the SDRAM port-2 arbiter slice.
package sdram_arb_pkg;

  localparam int ADDR_W      = 22;
  localparam int DATA_W      = 16;
  localparam int DS_W        = 2;
  localparam int NUM_REQ_DEF = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DONE  = 2'd2
  } arb_state_e;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sdram_arb_rr.sv
// Round-robin picker: first active request after last_grant_i, wrapping.
module sdram_arb_rr
  import sdram_arb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int IDX_W   = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   last_grant_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               any_o
);

  always_comb begin
    int unsigned cand;
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    cand    = 0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand = (32'(last_grant_i) + i) % NUM_REQ;
      if (!any_o && req_i[cand]) begin
        any_o         = 1'b1;
        grant_o[cand] = 1'b1;
        idx_o         = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/sdram_p2_arbiter.sv
// Round-robin arbiter multiplexing NUM_REQ requesters onto SDRAM port 2.
// Optional watchdog on the port-2 ack: define SDRAM_ARB_TIMEOUT_EN.
module sdram_p2_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int TIMEOUT = 1023
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      ram_ready,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [ADDR_W*NUM_REQ-1:0] req_addr,
  input  logic [DS_W*NUM_REQ-1:0]   req_ds,
  input  logic [DATA_W*NUM_REQ-1:0] req_din,
  output logic [NUM_REQ-1:0]        req_done,
  output logic [DATA_W-1:0]         req_dout,
  output logic                      req_err,
  output logic                      p2_cs,
  output logic                      p2_we,
  output logic [ADDR_W-1:0]         p2_addr,
  output logic [DS_W-1:0]           p2_ds,
  output logic [DATA_W-1:0]         p2_din,
  input  logic [DATA_W-1:0]         p2_dout,
  input  logic                      p2_ack
);

  localparam int IDX_W = idx_width(NUM_REQ);

  arb_state_e          state_q, state_d;
  logic                p2_cs_q, p2_cs_d;
  logic                p2_we_q, p2_we_d;
  logic [ADDR_W-1:0]   p2_addr_q, p2_addr_d;
  logic [DS_W-1:0]     p2_ds_q, p2_ds_d;
  logic [DATA_W-1:0]   p2_din_q, p2_din_d;
  logic                ack_ref_q, ack_ref_d;
  logic [IDX_W-1:0]    winner_q, winner_d;
  logic [IDX_W-1:0]    last_grant_q, last_grant_d;
  logic [NUM_REQ-1:0]  req_done_q, req_done_d;
  logic [DATA_W-1:0]   req_dout_q, req_dout_d;

  logic [NUM_REQ-1:0]  rr_gnt;
  logic [IDX_W-1:0]    rr_idx;
  logic                rr_any;

`ifdef SDRAM_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                to_q, to_d;
  logic                req_err_q, req_err_d;
`endif

  sdram_arb_rr #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .req_i        (req_valid),
    .last_grant_i (last_grant_q),
    .grant_o      (rr_gnt),
    .idx_o        (rr_idx),
    .any_o        (rr_any)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      p2_cs_q      <= 1'b0;
      p2_we_q      <= 1'b0;
      p2_addr_q    <= '0;
      p2_ds_q      <= '0;
      p2_din_q     <= '0;
      ack_ref_q    <= p2_ack;
      winner_q     <= '0;
      last_grant_q <= IDX_W'(NUM_REQ - 1);
      req_done_q   <= '0;
      req_dout_q   <= '0;
`ifdef SDRAM_ARB_TIMEOUT_EN
      cnt_q        <= '0;
      to_q         <= 1'b0;
      req_err_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      p2_cs_q      <= p2_cs_d;
      p2_we_q      <= p2_we_d;
      p2_addr_q    <= p2_addr_d;
      p2_ds_q      <= p2_ds_d;
      p2_din_q     <= p2_din_d;
      ack_ref_q    <= ack_ref_d;
      winner_q     <= winner_d;
      last_grant_q <= last_grant_d;
      req_done_q   <= req_done_d;
      req_dout_q   <= req_dout_d;
`ifdef SDRAM_ARB_TIMEOUT_EN
      cnt_q        <= cnt_d;
      to_q         <= to_d;
      req_err_q    <= req_err_d;
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    p2_cs_d      = p2_cs_q;
    p2_we_d      = p2_we_q;
    p2_addr_d    = p2_addr_q;
    p2_ds_d      = p2_ds_q;
    p2_din_d     = p2_din_q;
    ack_ref_d    = ack_ref_q;
    winner_d     = winner_q;
    last_grant_d = last_grant_q;
    req_done_d   = '0;
    req_dout_d   = req_dout_q;
`ifdef SDRAM_ARB_TIMEOUT_EN
    cnt_d        = cnt_q;
    to_d         = to_q;
    req_err_d    = 1'b0;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (ram_ready && rr_any) begin
          state_d   = ST_ISSUE;
          p2_cs_d   = 1'b1;
          winner_d  = rr_idx;
          p2_we_d   = |(req_we & rr_gnt);
          p2_addr_d = req_addr[int'(rr_idx)*ADDR_W +: ADDR_W];
          p2_ds_d   = req_ds[int'(rr_idx)*DS_W +: DS_W];
          p2_din_d  = req_din[int'(rr_idx)*DATA_W +: DATA_W];
          ack_ref_d = p2_ack;
`ifdef SDRAM_ARB_TIMEOUT_EN
          cnt_d     = '0;
          to_d      = 1'b0;
`endif
        end
      end

      ST_ISSUE: begin
        if (p2_ack != ack_ref_q) begin
          req_dout_d = p2_dout;
          p2_cs_d    = 1'b0;
          state_d    = ST_DONE;
        end
`ifdef SDRAM_ARB_TIMEOUT_EN
        // Watchdog fires on the TIMEOUT-th ISSUE cycle; ack level is
        // resampled so a late toggle cannot be mistaken for the next access.
        else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          req_dout_d = '1;
          p2_cs_d    = 1'b0;
          ack_ref_d  = p2_ack;
          to_d       = 1'b1;
          state_d    = ST_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end

      ST_DONE: begin
        req_done_d[winner_q] = 1'b1;
        last_grant_d         = winner_q;
        state_d              = ST_IDLE;
`ifdef SDRAM_ARB_TIMEOUT_EN
        req_err_d            = to_q;
`endif
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign req_done = req_done_q;
  assign req_dout = req_dout_q;
  assign p2_cs    = p2_cs_q;
  assign p2_we    = p2_we_q;
  assign p2_addr  = p2_addr_q;
  assign p2_ds    = p2_ds_q;
  assign p2_din   = p2_din_q;

`ifdef SDRAM_ARB_TIMEOUT_EN
  assign req_err = req_err_q;
`else
  assign req_err = 1'b0;
`endif

endmodule

// File: tb/tb_sdram_p2_arbiter.sv
// Directed bench for sdram_p2_arbiter; timeout expectations follow SDRAM_ARB_TIMEOUT_EN.
module tb_sdram_p2_arbiter;

  localparam int NR = 3;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            ram_ready;
  logic [NR-1:0]   req_valid;
  logic [NR-1:0]   req_we;
  logic [22*NR-1:0] req_addr;
  logic [2*NR-1:0] req_ds;
  logic [16*NR-1:0] req_din;
  logic [NR-1:0]   req_done;
  logic [15:0]     req_dout;
  logic            req_err;
  logic            p2_cs;
  logic            p2_we;
  logic [21:0]     p2_addr;
  logic [1:0]      p2_ds;
  logic [15:0]     p2_din;
  logic [15:0]     p2_dout;
  logic            p2_ack;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  sdram_p2_arbiter #(.NUM_REQ(NR), .TIMEOUT(15)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .ram_ready (ram_ready),
    .req_valid (req_valid),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_ds    (req_ds),
    .req_din   (req_din),
    .req_done  (req_done),
    .req_dout  (req_dout),
    .req_err   (req_err),
    .p2_cs     (p2_cs),
    .p2_we     (p2_we),
    .p2_addr   (p2_addr),
    .p2_ds     (p2_ds),
    .p2_din    (p2_din),
    .p2_dout   (p2_dout),
    .p2_ack    (p2_ack)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic toggle_ack(input logic [15:0] d);
    p2_dout = d;
    p2_ack  = ~p2_ack;
  endtask

  task automatic wait_cs(input int max, output int waited);
    waited = 0;
    while (p2_cs !== 1'b1 && waited < max) begin
      tick();
      waited++;
    end
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    ram_ready = 1'b1;
    req_valid = 3'b111;
    tick();
    tick();
    n_cmp++; if (p2_cs !== 1'b0) begin n_bad++; $display("FAIL reset_cs got %b want 0", p2_cs); end
    n_cmp++; if ({p2_we, p2_addr, p2_ds, p2_din} !== 41'd0) begin n_bad++; $display("FAIL reset_p2 got %h want 0", {p2_we, p2_addr, p2_ds, p2_din}); end
    n_cmp++; if ({req_done, req_err, req_dout} !== 20'd0) begin n_bad++; $display("FAIL reset_resp got %h want 0", {req_done, req_err, req_dout}); end
    req_valid = 3'b000;
    reset_n   = 1'b1;
    tick();
  endtask

  task automatic test_single_read();
    int hi;
    req_valid = 3'b001;
    tick();
    n_cmp++; if (p2_cs !== 1'b1) begin n_bad++; $display("FAIL read_cs_rise got %b want 1", p2_cs); end
    n_cmp++; if (p2_addr !== 22'h012345 || p2_we !== 1'b0) begin n_bad++; $display("FAIL read_addr got %h/%b want 012345/0", p2_addr, p2_we); end
    hi = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (p2_cs === 1'b1) hi++;
    end
    toggle_ack(16'hBEEF);
    tick();
    n_cmp++; if (hi != 6 || p2_cs !== 1'b0) begin n_bad++; $display("FAIL read_cs_len got %0d/%b want 6/0", hi, p2_cs); end
    n_cmp++; if (req_done !== 3'b000) begin n_bad++; $display("FAIL read_done_early got %b want 000", req_done); end
    tick();
    n_cmp++; if (req_done !== 3'b001 || req_dout !== 16'hBEEF) begin n_bad++; $display("FAIL read_done got %b/%h want 001/beef", req_done, req_dout); end
    req_valid = 3'b000;
    tick();
    n_cmp++; if (req_done !== 3'b000 || p2_cs !== 1'b0 || req_dout !== 16'hBEEF) begin n_bad++; $display("FAIL read_pulse got %b/%b/%h want 000/0/beef", req_done, p2_cs, req_dout); end
  endtask

  task automatic test_write();
    int stable;
    req_valid = 3'b100;
    tick();
    n_cmp++; if ({p2_cs, p2_we, p2_ds, p2_din} !== {1'b1, 1'b1, 2'b01, 16'hA55A}) begin n_bad++; $display("FAIL write_issue got %b%b %b %h want 11 01 a55a", p2_cs, p2_we, p2_ds, p2_din); end
    n_cmp++; if (p2_addr !== 22'h3F0F0F) begin n_bad++; $display("FAIL write_addr got %h want 3f0f0f", p2_addr); end
    stable = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if ({p2_cs, p2_we, p2_ds, p2_din} !== {1'b1, 1'b1, 2'b01, 16'hA55A}) stable = 0;
    end
    n_cmp++; if (stable != 1) begin n_bad++; $display("FAIL write_stable got %0d want 1", stable); end
    toggle_ack(16'h0000);
    tick();
    tick();
    n_cmp++; if (req_done !== 3'b100 || req_err !== 1'b0) begin n_bad++; $display("FAIL write_done got %b/%b want 100/0", req_done, req_err); end
    req_valid = 3'b000;
    tick();
  endtask

  task automatic test_contention();
    req_valid = 3'b111;
    for (int k = 0; k < 6; k++) begin
      int w;
      int e;
      logic [2:0]  oh;
      logic [21:0] a;
      e  = k % 3;
      oh = 3'b001 << e;
      a  = req_addr[22*e +: 22];
      wait_cs(10, w);
      n_cmp++; if (p2_cs !== 1'b1) begin n_bad++; $display("FAIL cont_grant%0d got cs %b want 1", k, p2_cs); end
      if (k > 0) begin
        n_cmp++; if (w != 1) begin n_bad++; $display("FAIL cont_gap%0d got %0d want 1", k, w); end
      end
      n_cmp++; if (p2_addr !== a) begin n_bad++; $display("FAIL cont_order%0d got %h want %h", k, p2_addr, a); end
      tick();
      tick();
      toggle_ack(16'h1000 + 16'(k));
      tick();
      tick();
      n_cmp++; if (req_done !== oh || req_dout !== 16'h1000 + 16'(k)) begin n_bad++; $display("FAIL cont_done%0d got %b/%h want %b/%h", k, req_done, req_dout, oh, 16'h1000 + 16'(k)); end
    end
    req_valid = 3'b000;
    tick();
  endtask

  task automatic test_withdraw_stray();
    int bad;
    bad = 0;
    toggle_ack(16'h5555);
    for (int i = 0; i < 3; i++) begin
      tick();
      if (p2_cs !== 1'b0 || req_done !== 3'b000) bad++;
    end
    n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL stray_ack got %0d bad cycles want 0", bad); end
    req_valid = 3'b010;
    tick();
    n_cmp++; if (p2_cs !== 1'b1 || p2_addr !== 22'h2ABCDE) begin n_bad++; $display("FAIL withdraw_grant got %b/%h want 1/2abcde", p2_cs, p2_addr); end
    req_valid = 3'b000;
    tick();
    tick();
    n_cmp++; if (p2_cs !== 1'b1) begin n_bad++; $display("FAIL withdraw_hold got %b want 1", p2_cs); end
    toggle_ack(16'h1234);
    tick();
    tick();
    n_cmp++; if (req_done !== 3'b010 || req_dout !== 16'h1234) begin n_bad++; $display("FAIL withdraw_done got %b/%h want 010/1234", req_done, req_dout); end
    tick();
  endtask

  task automatic test_ram_ready();
    int bad;
    bad = 0;
    ram_ready = 1'b0;
    req_valid = 3'b001;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (p2_cs !== 1'b0 || req_done !== 3'b000) bad++;
    end
    n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL notready_grant got %0d bad cycles want 0", bad); end
    ram_ready = 1'b1;
    tick();
    n_cmp++; if (p2_cs !== 1'b1 || p2_addr !== 22'h012345) begin n_bad++; $display("FAIL ready_grant got %b/%h want 1/012345", p2_cs, p2_addr); end
    ram_ready = 1'b0;
    tick();
    toggle_ack(16'h7E7E);
    tick();
    tick();
    n_cmp++; if (req_done !== 3'b001 || req_dout !== 16'h7E7E) begin n_bad++; $display("FAIL notready_finish got %b/%h want 001/7e7e", req_done, req_dout); end
    req_valid = 3'b000;
    ram_ready = 1'b1;
    tick();
  endtask

  task automatic test_reset_mid_issue();
    int bad;
    bad = 0;
    req_valid = 3'b010;
    tick();
    n_cmp++; if (p2_cs !== 1'b1) begin n_bad++; $display("FAIL rst_issue_grant got %b want 1", p2_cs); end
    tick();
    reset_n   = 1'b0;
    req_valid = 3'b000;
    tick();
    n_cmp++; if (p2_cs !== 1'b0 || req_done !== 3'b000) begin n_bad++; $display("FAIL rst_issue_drop got %b/%b want 0/000", p2_cs, req_done); end
    reset_n = 1'b1;
    toggle_ack(16'h9999);
    for (int i = 0; i < 4; i++) begin
      tick();
      if (p2_cs !== 1'b0 || req_done !== 3'b000) bad++;
    end
    n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL rst_issue_nodone got %0d bad cycles want 0", bad); end
  endtask

  task automatic test_timeout();
    int hi;
    req_valid = 3'b001;
    tick();
    n_cmp++; if (p2_cs !== 1'b1) begin n_bad++; $display("FAIL to_grant got %b want 1", p2_cs); end
    hi = 1;
`ifdef SDRAM_ARB_TIMEOUT_EN
    while (p2_cs === 1'b1 && hi < 40) begin
      tick();
      if (p2_cs === 1'b1) hi++;
    end
    n_cmp++; if (hi != 15 || p2_cs !== 1'b0) begin n_bad++; $display("FAIL to_len got %0d/%b want 15/0", hi, p2_cs); end
    tick();
    n_cmp++; if (req_done !== 3'b001 || req_err !== 1'b1 || req_dout !== 16'hFFFF) begin n_bad++; $display("FAIL to_done got %b/%b/%h want 001/1/ffff", req_done, req_err, req_dout); end
    req_valid = 3'b000;
    tick();
    n_cmp++; if (req_err !== 1'b0 || req_done !== 3'b000) begin n_bad++; $display("FAIL to_pulse got %b/%b want 0/000", req_err, req_done); end
`else
    for (int i = 0; i < 40; i++) begin
      tick();
      if (p2_cs === 1'b1 && req_done === 3'b000 && req_err === 1'b0) hi++;
    end
    n_cmp++; if (hi != 41) begin n_bad++; $display("FAIL to_hold got %0d want 41", hi); end
    req_valid = 3'b000;
    reset_n   = 1'b0;
    tick();
    n_cmp++; if (p2_cs !== 1'b0 || req_done !== 3'b000) begin n_bad++; $display("FAIL to_reset got %b/%b want 0/000", p2_cs, req_done); end
    reset_n = 1'b1;
    tick();
`endif
  endtask

  initial begin
    reset_n   = 1'b0;
    ram_ready = 1'b0;
    req_valid = '0;
    req_we    = 3'b100;
    req_addr  = {22'h3F0F0F, 22'h2ABCDE, 22'h012345};
    req_ds    = {2'b01, 2'b11, 2'b11};
    req_din   = {16'hA55A, 16'h2222, 16'h1111};
    p2_dout   = '0;
    p2_ack    = 1'b0;
    test_reset();
    test_single_read();
    test_write();
    test_contention();
    test_withdraw_stray();
    test_ram_ready();
    test_reset_mid_issue();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sdram_p2_arbiter.md
SDRAM_P2_ARBITER -- requirements
Module: sdram_p2_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 3: number of requesters sharing the SDRAM second port.
REQ-002 SHALL have parameter TIMEOUT, default 1023: watchdog limit in clk cycles (used only with SDRAM_ARB_TIMEOUT_EN).
REQ-003 SHALL use clk and reset_n: reset reset_n, synchronous, active-low; clock clk (SDRAM clock domain).
REQ-004 clk  input  1  SDRAM controller clock.
REQ-005 reset_n  input  1  synchronous active-low reset.
REQ-006 ram_ready  input  1  SDRAM initialisation complete.
REQ-007 req_valid  input  NUM_REQ  per-requester request, level, held until req_done.
REQ-008 req_we  input  NUM_REQ  per-requester write flag.
REQ-009 req_addr  input  22*NUM_REQ  per-requester word address, requester i at bits [22i+21:22i].
REQ-010 req_ds  input  2*NUM_REQ  per-requester upper/lower byte strobes.
REQ-011 req_din  input  16*NUM_REQ  per-requester write data.
REQ-012 req_done  output  NUM_REQ  one-cycle completion pulse to the granted requester.
REQ-013 req_dout  output  16  read data, valid in the req_done cycle and held until the next completion.
REQ-014 req_err  output  1  one-cycle timeout pulse, coincident with req_done.
REQ-015 p2_cs / p2_we  output  1 each  port-2 select and write.
REQ-016 p2_addr / p2_ds / p2_din  output  22 / 2 / 16  port-2 address, strobes and write data, registered.
REQ-017 p2_dout  input  16  port-2 read data.
REQ-018 p2_ack  input  1  port-2 completion, toggles once per finished access.

Function
REQ-019 SHALL implement FSM states IDLE, ISSUE and DONE.
REQ-020 IDLE: when ram_ready=1 and any req_valid=1, SHALL pick a winner round-robin starting at last_grant+1 (mod NUM_REQ), latch its we/addr/ds/din into the p2_* registers, record ack_ref<=p2_ack, assert p2_cs and go to ISSUE in the same edge.
REQ-021 ISSUE: p2_cs and all p2_* outputs SHALL stay stable; when p2_ack!=ack_ref, SHALL capture p2_dout into req_dout, deassert p2_cs and go to DONE.
REQ-022 DONE: SHALL pulse req_done[winner] for exactly one cycle, update last_grant to the winner and return to IDLE; no new grant is issued in this cycle (minimum one idle cycle between accesses).
REQ-023 Latency: p2_cs SHALL rise 1 cycle after req_valid is sampled in IDLE, and req_done SHALL follow the p2_ack toggle by 2 cycles.
REQ-024 Withdrawal of req_valid after grant SHALL be ignored; the latched access completes and req_done still pulses.
REQ-025 A p2_ack toggle seen in IDLE or DONE SHALL be ignored.
REQ-026 Simultaneous requests SHALL be served one per round-robin turn; no requester waits more than NUM_REQ-1 accesses.
REQ-027 With ram_ready=0, no grant SHALL be issued; an access already in ISSUE continues.

Reset
REQ-028 On reset_n=0: state=IDLE, p2_cs=0, p2_we=0, p2_addr/p2_ds/p2_din=0, req_done=0, req_err=0, req_dout=0, last_grant=NUM_REQ-1, ack_ref<=p2_ack; reset in ISSUE SHALL abandon the access without req_done.

Configuration
REQ-029 With SDRAM_ARB_TIMEOUT_EN defined: a cycle counter SHALL run in ISSUE; at count TIMEOUT, p2_cs SHALL drop, req_dout=16'hFFFF and req_done+req_err SHALL pulse via DONE; ack_ref<=p2_ack is resampled. Without it: no counter, wait indefinitely, req_err tied 0.

Structure
REQ-030 Package sdram_arb_pkg SHALL hold the FSM state enum, the address/data/strobe width constants (22/16/2) and the NUM_REQ default; sub-module sdram_arb_rr (round-robin picker: req vector + last_grant -> one-hot/index) SHALL hold the priority logic.

Verification
REQ-031 Single read: req_valid[0], addr 22'h012345; p2_ack toggles 6 cycles later with p2_dout 16'hBEEF -> p2_cs high 6 cycles, req_done[0] pulse, req_dout=16'hBEEF.
REQ-032 Write: req_valid[2], we=1, ds=2'b01, din 16'hA55A -> p2_we=1, p2_ds=2'b01, p2_din=16'hA55A stable until the ack toggle, then req_done[2].
REQ-033 Contention: all three requesters valid continuously -> grants 0,1,2,0,1,2, with one idle cycle between accesses.
REQ-034 Withdrawal/stray ack: req_valid[1] dropped during ISSUE still yields req_done[1]; an ack toggle in IDLE issues no grant and produces no req_done.
REQ-035 Timeout (macro on, TIMEOUT=15): no p2_ack toggle -> p2_cs drops after 15 cycles, req_err and req_done pulse, req_dout=16'hFFFF; macro off -> p2_cs held indefinitely.
REQ-036 Reset mid-ISSUE and ram_ready=0: p2_cs=0 next cycle, no req_done; no grant while ram_ready=0.
